// File: rtl/iob_timer_ctrl.sv
// iob_timer_ctrl: IOb bus initiator expanding timer commands into bus steps.
// Optional bus-step timeout enabled by defining IOB_TIMER_CTRL_TIMEOUT_EN.
module iob_timer_ctrl #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int RESET_ADDR     = 0,
  parameter int ENABLE_ADDR    = 1,
  parameter int SAMPLE_ADDR    = 2,
  parameter int DATA_LOW_ADDR  = 3,
  parameter int DATA_HIGH_ADDR = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  input  logic [1:0]            cmd_op,
  output logic                  cmd_ready,
  output logic                  busy,
  output logic                  ts_valid,
  output logic [2*DATA_W-1:0]   ts_data,
  output logic                  err,
  output logic                  m_valid,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic                  m_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_RESET   = 2'd0;
  localparam logic [1:0] OP_ENABLE  = 2'd1;
  localparam logic [1:0] OP_DISABLE = 2'd2;
  localparam logic [1:0] OP_SAMPLE  = 2'd3;

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_op;
  logic [1:0]          r_step;
  logic [DATA_W-1:0]   r_lo;
  logic [2*DATA_W-1:0] r_ts;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_wr;
  logic                w_one;
  logic                w_last;
  logic                w_step_done;
  logic                w_timeout;

  assign w_step_done = (r_state == S_ISSUE) && m_ready;

  // Step table: address, direction and write value of the current step.
  always_comb begin
    w_addr = '0;
    w_wr   = 1'b1;
    w_one  = 1'b0;
    w_last = 1'b1;
    unique case (r_op)
      OP_RESET: begin
        w_addr = ADDR_W'(RESET_ADDR);
        w_one  = (r_step == 2'd0);
        w_last = (r_step == 2'd1);
      end
      OP_ENABLE: begin
        w_addr = ADDR_W'(ENABLE_ADDR);
        w_one  = 1'b1;
      end
      OP_DISABLE: begin
        w_addr = ADDR_W'(ENABLE_ADDR);
      end
      OP_SAMPLE: begin
        w_addr = r_step[1]
               ? (r_step[0] ? ADDR_W'(DATA_HIGH_ADDR)
                            : ADDR_W'(DATA_LOW_ADDR))
               : ADDR_W'(SAMPLE_ADDR);
        w_wr   = ~r_step[1];
        w_one  = (r_step == 2'd0);
        w_last = (r_step == 2'd3);
      end
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (cmd_valid) w_next = S_ISSUE;
      S_ISSUE: begin
        if (w_step_done && w_last) w_next = S_DONE;
        else if (w_timeout)        w_next = S_IDLE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= OP_RESET;
      r_step  <= '0;
      r_lo    <= '0;
      r_ts    <= '0;
    end else begin
      r_state <= w_next;
      if (cmd_ready && cmd_valid) begin
        r_op   <= cmd_op;
        r_step <= '0;
      end
      if (w_step_done) begin
        if (!w_last) r_step <= r_step + 2'd1;
        if (r_op == OP_SAMPLE && r_step == 2'd2) r_lo <= m_rdata;
        // HIGH goes straight into ts_data so it is valid with ts_valid.
        if (r_op == OP_SAMPLE && w_last) r_ts <= {m_rdata, r_lo};
      end
    end
  end

`ifdef IOB_TIMER_CTRL_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] r_wait;
  logic              r_err;

  assign w_timeout = (r_state == S_ISSUE) && !m_ready &&
                     (r_wait == WAIT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err  <= w_timeout;
      r_wait <= (r_state == S_ISSUE && !m_ready)
              ? r_wait + WAIT_W'(1) : '0;
    end
  end

  assign err = r_err;
`else
  logic w_unused_to;
  assign w_unused_to = (TIMEOUT_CYCLES != 0);
  assign w_timeout   = 1'b0;
  assign err         = 1'b0;
`endif

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign ts_valid  = (r_state == S_DONE) && (r_op == OP_SAMPLE);
  assign ts_data   = r_ts;
  assign m_valid   = (r_state == S_ISSUE);
  assign m_addr    = m_valid ? w_addr : '0;
  assign m_wdata   = (m_valid && w_one) ? DATA_W'(1) : '0;
  assign m_wstrb   = (m_valid && w_wr) ? {(DATA_W/8){1'b1}} : '0;

endmodule

// File: tb/tb_iob_timer_ctrl.sv
// tb_iob_timer_ctrl: self-checking bench with a delay-programmable slave
// and a command-level model of the expected bus trace and timing.
module tb_iob_timer_ctrl;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic        cmd_ready, busy, ts_valid, err, m_valid;
  logic [63:0] ts_data;
  logic [15:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata = '0;
  logic        m_ready = 1'b0;

  typedef struct packed {
    logic [15:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } tr_t;

  tr_t         trace[$];
  tr_t         exp_q[$];
  int          dq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          stab_bad = 0;
  int          err_seen = 0;
  bit          noise = 1'b0;
  logic [31:0] g_lo = '0;
  logic [31:0] g_hi = '0;
  logic [63:0] exp_ts = '0;
  bit          in_step = 1'b0;
  int          cnt = 0;
  int          tgt = 1;
  tr_t         cur;

  always #5 clk = ~clk;

  iob_timer_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .busy(busy), .ts_valid(ts_valid), .ts_data(ts_data), .err(err),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rdata(m_rdata), .m_ready(m_ready)
  );

  // Slave: each step is readied after a programmed number of wait cycles.
  always @(negedge clk) begin
    if (rst || !m_valid) begin
      in_step = 1'b0;
      m_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      m_rdata = $urandom;
    end else begin
      if (!in_step) begin
        in_step = 1'b1;
        cnt = 0;
        tgt = (dq.size() > 0) ? dq.pop_front() : 1;
        cur = {m_addr, m_wstrb, m_wdata};
      end else if ({m_addr, m_wstrb, m_wdata} != cur) begin
        stab_bad++;
      end
      if (cnt >= tgt) begin
        m_ready = 1'b1;
        in_step = 1'b0;
        trace.push_back(cur);
        m_rdata = (m_addr == 16'd3) ? g_lo :
                  (m_addr == 16'd4) ? g_hi : $urandom;
      end else begin
        m_ready = 1'b0;
        cnt++;
        m_rdata = $urandom;
      end
    end
    if (err) err_seen++;
  end

  function automatic void build_exp(input logic [1:0] op);
    case (op)
      2'd0: begin
        exp_q.push_back({16'd0, 4'hF, 32'd1});
        exp_q.push_back({16'd0, 4'hF, 32'd0});
      end
      2'd1: exp_q.push_back({16'd1, 4'hF, 32'd1});
      2'd2: exp_q.push_back({16'd1, 4'hF, 32'd0});
      default: begin
        exp_q.push_back({16'd2, 4'hF, 32'd1});
        exp_q.push_back({16'd2, 4'hF, 32'd0});
        exp_q.push_back({16'd3, 4'h0, 32'd0});
        exp_q.push_back({16'd4, 4'h0, 32'd0});
      end
    endcase
  endfunction

  function automatic int nsteps(input logic [1:0] op);
    return (op == 2'd3) ? 4 : (op == 2'd0) ? 2 : 1;
  endfunction

  task automatic run_cmd(input logic [1:0] op, output int ts_cyc,
                         output int ts_n, output int rdy_cyc,
                         output int busy_n);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    ts_cyc = -1; ts_n = 0; rdy_cyc = -1; busy_n = 0;
    for (int k = 1; k <= 300 && rdy_cyc < 0; k++) begin
      @(negedge clk);
      if (ts_valid) begin
        ts_n++;
        if (ts_cyc < 0) ts_cyc = k;
      end
      if (busy) busy_n++;
      if (cmd_ready) rdy_cyc = k;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({cmd_ready, busy, ts_valid, err, m_valid} !== 5'b10000) begin
      n_bad++;
      $display("FAIL reset_ctrl got %b exp 10000",
               {cmd_ready, busy, ts_valid, err, m_valid});
    end
    n_cmp++;
    if (ts_data !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_ts got %h exp 0", ts_data);
    end
    n_cmp++;
    if ({m_addr, m_wdata, m_wstrb} !== 52'd0) begin
      n_bad++;
      $display("FAIL reset_bus got %h exp 0", {m_addr, m_wdata, m_wstrb});
    end
    rst = 1'b0;
  endtask

  task automatic test_enable_sample();
    int tc, tn, rc, bn;
    trace.delete(); exp_q.delete();
    g_lo = 32'h0000_0010; g_hi = 32'h0000_0002;
    build_exp(2'd1); build_exp(2'd3);
    dq = '{1};
    run_cmd(2'd1, tc, tn, rc, bn);
    n_cmp++;
    if (bn !== 3 || tn !== 0) begin
      n_bad++;
      $display("FAIL enable_timing got busy=%0d ts=%0d exp 3/0", bn, tn);
    end
    dq = '{1, 1, 1, 1};
    run_cmd(2'd3, tc, tn, rc, bn);
    exp_ts = 64'h0000_0002_0000_0010;
    n_cmp++;
    if (tc !== 9 || tn !== 1 || rc !== 10) begin
      n_bad++;
      $display("FAIL sample_timing got ts@%0d x%0d rdy@%0d exp 9 x1 10",
               tc, tn, rc);
    end
    n_cmp++;
    if (ts_data !== exp_ts) begin
      n_bad++;
      $display("FAIL sample_data got %h exp %h", ts_data, exp_ts);
    end
    n_cmp++;
    if (trace.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL es_trace_len got %0d exp %0d", trace.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_cmp++;
        if (trace[i] !== exp_q[i]) begin
          n_bad++;
          $display("FAIL es_trace[%0d] got %h exp %h", i, trace[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_cmd();
    int tc, tn, rc, bn;
    trace.delete(); exp_q.delete();
    build_exp(2'd0);
    dq = '{1, 1};
    run_cmd(2'd0, tc, tn, rc, bn);
    n_cmp++;
    if (tn !== 0 || bn !== 5 || ts_data !== exp_ts) begin
      n_bad++;
      $display("FAIL resetcmd got ts=%0d busy=%0d data=%h exp 0/5/%h",
               tn, bn, ts_data, exp_ts);
    end
    n_cmp++;
    if (trace.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL rc_trace_len got %0d exp %0d", trace.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_cmp++;
        if (trace[i] !== exp_q[i]) begin
          n_bad++;
          $display("FAIL rc_trace[%0d] got %h exp %h", i, trace[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_wait_states();
    int tc, tn, rc, bn;
    stab_bad = 0;
    g_lo = $urandom; g_hi = $urandom;
    dq = '{1, 1, 6, 1};
    run_cmd(2'd3, tc, tn, rc, bn);
    exp_ts = {g_hi, g_lo};
    n_cmp++;
    if (tc !== 14 || tn !== 1) begin
      n_bad++;
      $display("FAIL wait_timing got ts@%0d x%0d exp 14 x1", tc, tn);
    end
    n_cmp++;
    if (ts_data !== exp_ts) begin
      n_bad++;
      $display("FAIL wait_data got %h exp %h", ts_data, exp_ts);
    end
    n_cmp++;
    if (stab_bad !== 0) begin
      n_bad++;
      $display("FAIL wait_stable got %0d changes exp 0", stab_bad);
    end
  endtask

  task automatic test_busy_ignore();
    int acc;
    trace.delete(); exp_q.delete();
    build_exp(2'd3); build_exp(2'd1);
    g_lo = $urandom; g_hi = $urandom;
    dq = '{1, 1, 1, 1, 1};
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 2'd3;
    @(posedge clk);
    #1 cmd_op = 2'd1;
    acc = -1;
    for (int k = 1; k <= 40 && acc < 0; k++) begin
      @(negedge clk);
      if (cmd_ready) acc = k;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    exp_ts = {g_hi, g_lo};
    n_cmp++;
    if (acc !== 10) begin
      n_bad++;
      $display("FAIL busy_accept got %0d exp 10", acc);
    end
    n_cmp++;
    if (ts_data !== exp_ts) begin
      n_bad++;
      $display("FAIL busy_data got %h exp %h", ts_data, exp_ts);
    end
    n_cmp++;
    if (trace.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL bi_trace_len got %0d exp %0d", trace.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_cmp++;
        if (trace[i] !== exp_q[i]) begin
          n_bad++;
          $display("FAIL bi_trace[%0d] got %h exp %h", i, trace[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_rst_mid();
    bit found;
    int pulses;
    dq = '{1, 1, 1, 1};
    g_lo = $urandom; g_hi = $urandom;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 2'd3;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (m_valid && m_addr == 16'd3) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL rst_mid_reach got 0 exp 1");
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    exp_ts = '0;
    n_cmp++;
    if ({m_valid, busy, ts_valid, cmd_ready} !== 4'b0001) begin
      n_bad++;
      $display("FAIL rst_mid_ctrl got %b exp 0001",
               {m_valid, busy, ts_valid, cmd_ready});
    end
    n_cmp++;
    if (ts_data !== exp_ts || {m_addr, m_wstrb, m_wdata} !== 52'd0) begin
      n_bad++;
      $display("FAIL rst_mid_data got %h bus %h exp 0", ts_data,
               {m_addr, m_wstrb, m_wdata});
    end
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (ts_valid) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++;
      $display("FAIL rst_mid_tsvalid got %0d exp 0", pulses);
    end
    dq.delete();
  endtask

  task automatic test_random();
    int tc, tn, rc, bn, sum, d;
    logic [1:0] op;
    noise = 1'b1;
    for (int it = 0; it < 25; it++) begin
      op = 2'($urandom_range(0, 3));
      g_lo = $urandom; g_hi = $urandom;
      trace.delete(); exp_q.delete(); dq.delete();
      build_exp(op);
      sum = 0;
      for (int s = 0; s < nsteps(op); s++) begin
        d = $urandom_range(0, 3);
        dq.push_back(d);
        sum += d + 1;
      end
      run_cmd(op, tc, tn, rc, bn);
      if (op == 2'd3) exp_ts = {g_hi, g_lo};
      n_cmp++;
      if (rc !== sum + 2 || bn !== sum + 1) begin
        n_bad++;
        $display("FAIL rnd%0d_timing op=%0d got rdy@%0d busy=%0d exp %0d/%0d",
                 it, op, rc, bn, sum + 2, sum + 1);
      end
      n_cmp++;
      if (tn !== ((op == 2'd3) ? 1 : 0) ||
          (op == 2'd3 && tc !== sum + 1)) begin
        n_bad++;
        $display("FAIL rnd%0d_ts op=%0d got x%0d @%0d exp @%0d",
                 it, op, tn, tc, sum + 1);
      end
      n_cmp++;
      if (ts_data !== exp_ts) begin
        n_bad++;
        $display("FAIL rnd%0d_data got %h exp %h", it, ts_data, exp_ts);
      end
      n_cmp++;
      if (trace.size() != exp_q.size()) begin
        n_bad++;
        $display("FAIL rnd%0d_trace_len got %0d exp %0d", it,
                 trace.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          n_cmp++;
          if (trace[i] !== exp_q[i]) begin
            n_bad++;
            $display("FAIL rnd%0d_trace[%0d] got %h exp %h", it, i,
                     trace[i], exp_q[i]);
          end
        end
      end
    end
    noise = 1'b0;
  endtask

`ifdef IOB_TIMER_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int vcnt, rdy, e0;
    dq = '{100000};
    e0 = err_seen;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 2'd1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    vcnt = 0; rdy = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (m_valid) vcnt++;
      if (cmd_ready && rdy < 0) rdy = k;
    end
    n_cmp++;
    if (vcnt !== TO || rdy !== TO + 1) begin
      n_bad++;
      $display("FAIL timeout_drop got valid=%0d rdy@%0d exp %0d/%0d",
               vcnt, rdy, TO, TO + 1);
    end
    n_cmp++;
    if (err_seen - e0 !== 1 || ts_data !== exp_ts) begin
      n_bad++;
      $display("FAIL timeout_err got %0d pulses data %h exp 1 %h",
               err_seen - e0, ts_data, exp_ts);
    end
    dq.delete();
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_enable_sample();
    test_reset_cmd();
    test_wait_states();
    test_busy_ignore();
    test_rst_mid();
    test_random();
`ifdef IOB_TIMER_CTRL_TIMEOUT_EN
    test_timeout();
`else
    n_cmp++;
    if (err_seen !== 0) begin
      n_bad++;
      $display("FAIL err_tied got %0d pulses exp 0", err_seen);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
